// File: rtl/decode_exec_if.sv
// decode_exec_if: bundle between the Decode stage, the hazard unit and the
// Decode->Execute pipeline register.
//   D-side  : StallE/FlushE (from hazard unit), ValidD, decoded control,
//             FlagWriteD, CondD, RD1D/RD2D/ExtImmD, RA1D/RA2D/WA3D
//   E-side  : registered copies of the above (…E), ValidE, BubbleCnt
// Modports:
//   slave  - the pipeline register (consumes D side, produces E side)
//   master - the producer/observer (drives D side, reads E side)
interface decode_exec_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  // hazard control
  logic                 StallE;
  logic                 FlushE;
  // decode side
  logic                 ValidD;
  logic                 PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
  logic [1:0]           ALUControlD;
  logic [1:0]           FlagWriteD;
  logic [3:0]           CondD;
  logic [WIDTH-1:0]     RD1D, RD2D, ExtImmD;
  logic [3:0]           RA1D, RA2D, WA3D;
  // execute side
  logic                 PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
  logic [1:0]           ALUControlE;
  logic [1:0]           FlagWriteE;
  logic [3:0]           CondE;
  logic [WIDTH-1:0]     RD1E, RD2E, ExtImmE;
  logic [3:0]           RA1E, RA2E, WA3E;
  logic                 ValidE;
  logic [CNT_WIDTH-1:0] BubbleCnt;

  modport slave (
    input  StallE, FlushE, ValidD,
    input  PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
    input  ALUControlD, FlagWriteD, CondD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D,
    output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE,
    output ALUControlE, FlagWriteE, CondE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E,
    output ValidE, BubbleCnt
  );

  modport master (
    output StallE, FlushE, ValidD,
    output PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
    output ALUControlD, FlagWriteD, CondD, RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D,
    input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE,
    input  ALUControlE, FlagWriteE, CondE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E,
    input  ValidE, BubbleCnt
  );
endinterface

// File: rtl/decode_exec_reg.sv
// decode_exec_reg: Decode->Execute pipeline register of the pipelined ARM core.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears all E state and BubbleCnt
//   de    - decode_exec_if.slave: D-side inputs, E-side registered outputs
// Update priority per edge: reset > FlushE > StallE > load.
// A non-valid slot loads its data/register numbers/condition but has all
// side-effecting control (and flag writes) squashed. BubbleCnt counts edges
// that put a bubble into E and saturates at all-ones.
// Every output is a flop; there is no input->output combinational path.
module decode_exec_reg #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  decode_exec_if.slave  de
);

  typedef struct packed {
    logic             pcsrc;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             branch;
    logic             alu_src;
    logic [1:0]       alu_control;
    logic [1:0]       flag_write;
    logic [3:0]       cond;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] ext_imm;
    logic [3:0]       ra1;
    logic [3:0]       ra2;
    logic [3:0]       wa3;
    logic             valid;
  } e_stage_t;

  e_stage_t             e_q, e_d;
  e_stage_t             load_s;
  logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
  logic                 bubble;

  // What E would capture on a plain load. Control is gated by ValidD so a
  // dead slot can never write a register, memory or flags, or branch.
  always_comb begin
    load_s             = '0;
    load_s.valid       = de.ValidD;
    load_s.pcsrc       = de.PCSrcD    & de.ValidD;
    load_s.reg_write   = de.RegWriteD & de.ValidD;
    load_s.mem_to_reg  = de.MemtoRegD & de.ValidD;
    load_s.mem_write   = de.MemWriteD & de.ValidD;
    load_s.branch      = de.BranchD   & de.ValidD;
    load_s.alu_src     = de.ALUSrcD   & de.ValidD;
    load_s.alu_control = de.ALUControlD & {2{de.ValidD}};
    load_s.flag_write  = de.FlagWriteD  & {2{de.ValidD}};
    load_s.cond        = de.CondD;
    load_s.rd1         = de.RD1D;
    load_s.rd2         = de.RD2D;
    load_s.ext_imm     = de.ExtImmD;
    load_s.ra1         = de.RA1D;
    load_s.ra2         = de.RA2D;
    load_s.wa3         = de.WA3D;
  end

  // Next-state: flush beats stall; stall holds everything incl. the counter.
  always_comb begin
    e_d          = e_q;
    bubble_cnt_d = bubble_cnt_q;
    bubble       = de.FlushE | (~de.StallE & ~de.ValidD);
    if (de.FlushE)       e_d = '0;
    else if (!de.StallE) e_d = load_s;
    if (bubble && (bubble_cnt_q != {CNT_WIDTH{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q          <= '0;
      bubble_cnt_q <= '0;
    end else begin
      e_q          <= e_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign de.PCSrcE      = e_q.pcsrc;
  assign de.RegWriteE   = e_q.reg_write;
  assign de.MemtoRegE   = e_q.mem_to_reg;
  assign de.MemWriteE   = e_q.mem_write;
  assign de.BranchE     = e_q.branch;
  assign de.ALUSrcE     = e_q.alu_src;
  assign de.ALUControlE = e_q.alu_control;
  assign de.FlagWriteE  = e_q.flag_write;
  assign de.CondE       = e_q.cond;
  assign de.RD1E        = e_q.rd1;
  assign de.RD2E        = e_q.rd2;
  assign de.ExtImmE     = e_q.ext_imm;
  assign de.RA1E        = e_q.ra1;
  assign de.RA2E        = e_q.ra2;
  assign de.WA3E        = e_q.wa3;
  assign de.ValidE      = e_q.valid;
  assign de.BubbleCnt   = bubble_cnt_q;

endmodule

// File: tb/tb_decode_exec_reg.sv
module tb_decode_exec_reg;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_exec_if #(.WIDTH(32), .CNT_WIDTH(16)) de ();
  decode_exec_if #(.WIDTH(32), .CNT_WIDTH(4))  ds ();

  decode_exec_reg #(.WIDTH(32), .CNT_WIDTH(16)) dut   (.clk(clk), .reset(reset), .de(de));
  decode_exec_reg #(.WIDTH(32), .CNT_WIDTH(4))  dut_s (.clk(clk), .reset(reset), .de(ds));

  // narrow-counter instance sees the same stimulus
  assign ds.StallE = de.StallE;       assign ds.FlushE = de.FlushE;
  assign ds.ValidD = de.ValidD;       assign ds.PCSrcD = de.PCSrcD;
  assign ds.RegWriteD = de.RegWriteD; assign ds.MemtoRegD = de.MemtoRegD;
  assign ds.MemWriteD = de.MemWriteD; assign ds.BranchD = de.BranchD;
  assign ds.ALUSrcD = de.ALUSrcD;     assign ds.ALUControlD = de.ALUControlD;
  assign ds.FlagWriteD = de.FlagWriteD; assign ds.CondD = de.CondD;
  assign ds.RD1D = de.RD1D;           assign ds.RD2D = de.RD2D;
  assign ds.ExtImmD = de.ExtImmD;     assign ds.RA1D = de.RA1D;
  assign ds.RA2D = de.RA2D;           assign ds.WA3D = de.WA3D;

  typedef struct packed {
    logic pcsrc, regwrite, memtoreg, memwrite, branch, alusrc;
    logic [1:0] aluc, fw;
    logic [3:0] cond;
    logic [31:0] rd1, rd2, imm;
    logic [3:0] ra1, ra2, wa3;
    logic valid;
  } e_t;

  typedef struct {
    e_t          e;
    int unsigned c16;
    int unsigned c4;
  } sb_t;

  sb_t  q[$];
  e_t   m;
  int unsigned c16, c4;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  function automatic int unsigned sat_inc(int unsigned c, int unsigned maxv);
    return (c >= maxv) ? maxv : c + 1;
  endfunction

  // Reference: what E must hold after the coming edge, from the rules alone.
  task automatic tick();
    if (reset) begin
      m = '0; c16 = 0; c4 = 0;
    end else if (de.FlushE) begin
      m = '0;
      c16 = sat_inc(c16, 65535); c4 = sat_inc(c4, 15);
    end else if (!de.StallE) begin
      m.valid = de.ValidD;
      m.cond = de.CondD; m.rd1 = de.RD1D; m.rd2 = de.RD2D; m.imm = de.ExtImmD;
      m.ra1 = de.RA1D; m.ra2 = de.RA2D; m.wa3 = de.WA3D;
      if (de.ValidD) begin
        m.pcsrc = de.PCSrcD; m.regwrite = de.RegWriteD; m.memtoreg = de.MemtoRegD;
        m.memwrite = de.MemWriteD; m.branch = de.BranchD; m.alusrc = de.ALUSrcD;
        m.aluc = de.ALUControlD; m.fw = de.FlagWriteD;
      end else begin
        {m.pcsrc, m.regwrite, m.memtoreg, m.memwrite, m.branch, m.alusrc} = '0;
        m.aluc = 2'b00; m.fw = 2'b00;
        c16 = sat_inc(c16, 65535); c4 = sat_inc(c4, 15);
      end
    end
    q.push_back('{e: m, c16: c16, c4: c4});
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // Monitor: every edge the DUT presents a new E state; compare against
  // the oldest pending expectation.
  initial begin
    e_t act;
    sb_t exp_s;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      act = '{pcsrc: de.PCSrcE, regwrite: de.RegWriteE, memtoreg: de.MemtoRegE,
              memwrite: de.MemWriteE, branch: de.BranchE, alusrc: de.ALUSrcE,
              aluc: de.ALUControlE, fw: de.FlagWriteE, cond: de.CondE,
              rd1: de.RD1E, rd2: de.RD2E, imm: de.ExtImmE,
              ra1: de.RA1E, ra2: de.RA2E, wa3: de.WA3E, valid: de.ValidE};
      tests++;
      if (!de.ValidE && ({de.PCSrcE, de.RegWriteE, de.MemWriteE, de.BranchE, de.FlagWriteE} != 6'b0)) begin
        fails++;
        $display("FAIL valid_invariant cyc=%0d ctrl=%b", cyc,
                 {de.PCSrcE, de.RegWriteE, de.MemWriteE, de.BranchE, de.FlagWriteE});
      end
      if (q.size() != 0) begin
        exp_s = q.pop_front();
        tests += 3;
        if (act !== exp_s.e) begin
          fails++;
          $display("FAIL e_stage cyc=%0d got=%h want=%h", cyc, act, exp_s.e);
        end
        if (de.BubbleCnt !== 16'(exp_s.c16)) begin
          fails++;
          $display("FAIL bubble_cnt16 cyc=%0d got=%0d want=%0d", cyc, de.BubbleCnt, exp_s.c16);
        end
        if (ds.BubbleCnt !== 4'(exp_s.c4)) begin
          fails++;
          $display("FAIL bubble_cnt4 cyc=%0d got=%0d want=%0d", cyc, ds.BubbleCnt, exp_s.c4);
        end
      end
    end
  end

  task automatic clear_d();
    de.StallE = 0; de.FlushE = 0; de.ValidD = 0;
    de.PCSrcD = 0; de.RegWriteD = 0; de.MemtoRegD = 0; de.MemWriteD = 0;
    de.BranchD = 0; de.ALUSrcD = 0; de.ALUControlD = 0; de.FlagWriteD = 0;
    de.CondD = 0; de.RD1D = 0; de.RD2D = 0; de.ExtImmD = 0;
    de.RA1D = 0; de.RA2D = 0; de.WA3D = 0;
  endtask

  task automatic rand_d();
    de.PCSrcD = 1'($urandom); de.RegWriteD = 1'($urandom); de.MemtoRegD = 1'($urandom);
    de.MemWriteD = 1'($urandom); de.BranchD = 1'($urandom); de.ALUSrcD = 1'($urandom);
    de.ALUControlD = 2'($urandom); de.FlagWriteD = 2'($urandom); de.CondD = 4'($urandom);
    de.RD1D = $urandom; de.RD2D = $urandom; de.ExtImmD = $urandom;
    de.RA1D = 4'($urandom); de.RA2D = 4'($urandom); de.WA3D = 4'($urandom);
  endtask

  initial begin
    m = '0; c16 = 0; c4 = 0;
    clear_d();
    rand_d();
    de.FlushE = 1'b1; de.ValidD = 1'b1;  // reset must win over flush/load
    reset = 1'b1;
    tick(); tick();
    chk("reset_valid", 32'(de.ValidE), 32'd0);
    chk("reset_cond",  32'(de.CondE),  32'd0);
    chk("reset_cnt",   32'(de.BubbleCnt), 32'd0);
    reset = 1'b0;

    // 1: plain valid load
    clear_d();
    de.ValidD = 1; de.RegWriteD = 1; de.ALUControlD = 2'b01; de.FlagWriteD = 2'b11;
    de.CondD = 4'hE; de.RD1D = 32'h12345678; de.WA3D = 4'd3;
    tick();
    chk("s1_rd1",   de.RD1E, 32'h12345678);
    chk("s1_valid", 32'(de.ValidE), 32'd1);
    chk("s1_fw",    32'(de.FlagWriteE), 32'd3);
    chk("s1_cnt",   32'(de.BubbleCnt), 32'd0);

    // 2: stall holds for 3 cycles, then release
    de.StallE = 1; de.RD1D = 32'hDEADBEEF;
    repeat (3) begin
      tick();
      chk("s2_hold_rd1", de.RD1E, 32'h12345678);
    end
    de.StallE = 0;
    tick();
    chk("s2_release_rd1", de.RD1E, 32'hDEADBEEF);

    // 3: flush overrides stall
    de.FlushE = 1; de.StallE = 1; de.MemWriteD = 1;
    tick();
    chk("s3_memwrite", 32'(de.MemWriteE), 32'd0);
    chk("s3_rd1",      de.RD1E, 32'd0);
    chk("s3_cnt",      32'(de.BubbleCnt), 32'd1);
    de.FlushE = 0; de.StallE = 0;

    // 4: invalid slot squashes side effects, keeps data
    clear_d();
    de.RegWriteD = 1; de.MemWriteD = 1; de.FlagWriteD = 2'b10; de.RD2D = 32'hA5A5A5A5;
    tick();
    chk("s4_regwrite", 32'(de.RegWriteE), 32'd0);
    chk("s4_fw",       32'(de.FlagWriteE), 32'd0);
    chk("s4_rd2",      de.RD2E, 32'hA5A5A5A5);
    chk("s4_cnt",      32'(de.BubbleCnt), 32'd2);

    // 5: saturate the 4-bit counter, then reset mid-stream
    de.FlushE = 1;
    repeat (20) tick();
    chk("s5_sat4",  32'(ds.BubbleCnt), 32'hF);
    chk("s5_cnt16", 32'(de.BubbleCnt), 32'd22);
    reset = 1;
    tick();
    chk("s5_rst4",  32'(ds.BubbleCnt), 32'd0);
    chk("s5_rst16", 32'(de.BubbleCnt), 32'd0);
    reset = 0; de.FlushE = 0;

    // 6: random traffic
    for (int i = 0; i < 10000; i++) begin
      rand_d();
      de.StallE = ($urandom_range(3) == 0);
      de.FlushE = ($urandom_range(7) == 0);
      de.ValidD = ($urandom_range(3) != 0);
      reset     = ($urandom_range(499) == 0);
      tick();
    end
    reset = 0;

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout pending=%0d", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_exec_reg.md
Name: decode_exec_reg

Overview:
- Decode→Execute pipeline register of the pipelined ARM core.
- Captures decoded control, register operands, extended immediate and condition field; drives the Execute stage: ALU, condition unit (CondE, FlagWriteE), forwarding muxes and hazard unit.
- Supports stall (hold), flush (bubble insertion) and a valid bit.
- Includes a saturating bubble counter for performance debug.

Parameters:
- WIDTH, 32, datapath width of RD1/RD2/ExtImm.
- CNT_WIDTH, 16, width of the bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- StallE  in  1  hold all E-stage contents.
- FlushE  in  1  load a bubble into E.
- ValidD  in  1  decode slot holds a real instruction.
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  in  1 each  decoded control.
- ALUControlD  in  2  ALU operation.
- FlagWriteD  in  2  flag-group write enables: [1]=NZ, [0]=CV.
- CondD  in  4  condition field Instr[31:28].
- RD1D, RD2D  in  WIDTH  register-file read data.
- ExtImmD  in  WIDTH  extended immediate.
- RA1D, RA2D, WA3D  in  4 each  source/destination register numbers.
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE  out  1 each  registered control.
- ALUControlE  out  2  registered ALU operation.
- FlagWriteE  out  2  registered flag-group write enables.
- CondE  out  4  registered condition field.
- RD1E, RD2E, ExtImmE  out  WIDTH  registered data.
- RA1E, RA2E, WA3E  out  4 each  registered register numbers.
- ValidE  out  1  E slot holds a real instruction.
- BubbleCnt  out  CNT_WIDTH  saturating count of bubbles entering E.

Behaviour:
- All state updates on the rising clk edge. Update priority: reset > FlushE > StallE > load.
- reset: every output = 0, including CondE=4'b0000 and BubbleCnt=0. Reset asserted mid-operation discards E contents in the same edge.
- FlushE=1:
  - All control outputs, ValidE, FlagWriteE, CondE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E = 0.
  - FlushE overrides a simultaneous StallE.
- StallE=1, FlushE=0: all outputs hold, BubbleCnt holds.
- Load (StallE=0, FlushE=0): every E output takes its D input after exactly one cycle.
  - ValidE = ValidD.
  - If ValidD=0, control outputs and FlagWriteE are forced to 0; data, register numbers and CondE load normally.
  - A non-valid slot must never write a register, memory or flags, nor take a branch.
- Bubble definition: an edge with reset=0 where FlushE=1, or where StallE=0 and ValidD=0.
- BubbleCnt: +1 per bubble; saturates at all-ones with no wrap. Only reset clears it.
- No combinational path from any input to any output.
- Invariant: ValidE=0 implies PCSrcE, RegWriteE, MemWriteE, BranchE, FlagWriteE are all 0.

Test Plan:
1. Reset, then load ValidD=1, RegWriteD=1, ALUControlD=2'b01, FlagWriteD=2'b11, CondD=4'hE, RD1D=32'h12345678, WA3D=4'd3 → one cycle later all match, ValidE=1, BubbleCnt=0.
2. E holds the scenario-1 instruction; StallE=1 for 3 cycles while D inputs change to RD1D=32'hDEADBEEF → RD1E stays 32'h12345678 throughout. Release StallE → new values appear the next cycle.
3. FlushE=1 and StallE=1 together with a valid D instruction (MemWriteD=1) → next cycle all outputs 0, ValidE=0, BubbleCnt increments by 1.
4. ValidD=0 with RegWriteD=1, MemWriteD=1, FlagWriteD=2'b10, RD2D=32'hA5A5A5A5 → RegWriteE=0, MemWriteE=0, FlagWriteE=0, RD2E=32'hA5A5A5A5, ValidE=0, BubbleCnt +1.
5. With CNT_WIDTH=4, apply 20 consecutive flush cycles → BubbleCnt reaches 4'hF and stays there. Assert reset mid-stream → BubbleCnt=0 and all outputs 0 the next cycle.
6. Random StallE/FlushE/ValidD for 10k cycles against a reference model → outputs match each cycle, and the ValidE invariant always holds.
